seq_det_ctrl: RTL and testbench

Programmable serial-pattern detection controller for the sequence-detector datapath. It accepts a run-time pattern (1–8 bits), a length and a match-count target through a configuration handshake. It arms on a start pulse, scans a qualified serial bit stream, and counts matches. It signals completion when the target is reached. It replaces fixed-pattern FSMs such as the 110100 detector with one configurable, sequenced resource that host logic can reprogram between runs.

---
 rtl/seq_det_ctrl_if.sv | 44 ++++
 rtl/seq_det_ctrl.sv | 143 ++++++++++++++
 tb/tb_seq_det_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl_if
// Description : Bundles the configuration handshake, run control, serial
//               input stream and status outputs of seq_det_ctrl.
//               master : host side (drives config/control/stream).
//               slave  : controller side (drives handshake ready/status).
// Parameters  : PAT_W - maximum pattern length in bits
//               CNT_W - width of match counter and target
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_det_ctrl_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [3:0]       cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_bit;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    logic             ack;
    logic             err;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_target,
        output start, abort, in_valid, in_bit, ack,
        input  cfg_ready, busy, match, match_cnt, done, err
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_target,
        input  start, abort, in_valid, in_bit, ack,
        output cfg_ready, busy, match, match_cnt, done, err
    );
endinterface
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Programmable serial-pattern detection controller. A pattern
//               of 1..PAT_W bits, its length and a match-count target are
//               loaded through a valid/ready handshake. A start pulse arms a
//               run that scans the qualified serial stream, counts matches
//               and raises done when the target is reached.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - seq_det_ctrl_if.slave (config, control, stream,
//                       status)
// Options     : SEQ_DET_OVERLAP_EN - when defined, detection is overlapping
//               (history/fill kept after a match); otherwise each match
//               needs len fresh bits.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    seq_det_ctrl_if.slave  bus
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_armed = 2'd1;
    localparam logic [1:0] c_run   = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [3:0]       r_len;
    logic [CNT_W-1:0] r_target;
    logic [PAT_W-1:0] r_hist;
    logic [3:0]       r_fill;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic             w_cfg_legal;
    logic [PAT_W-1:0] w_mask;
    logic [PAT_W-1:0] w_hist_next;
    logic [3:0]       w_fill_next;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cfg_legal = (bus.cfg_len != 4'd0) &&
                         (32'(bus.cfg_len) <= PAT_W) &&
                         (bus.cfg_target != '0);

    // Selects the low r_len bits of history/pattern for comparison.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            w_mask[i] = (32'(r_len) > 32'(i));
        end
    end

    // Newest bit enters at the LSB, so the first pattern bit ends up at
    // bit[len-1] once len bits have been collected.
    assign w_hist_next = {r_hist[PAT_W-2:0], bus.in_bit};
    assign w_fill_next = (r_fill >= r_len) ? r_len : (r_fill + 4'd1);
    assign w_hit       = (w_fill_next >= r_len) &&
                         (((w_hist_next ^ r_pattern) & w_mask) == '0);
    assign w_cnt_inc   = r_cnt + c_cnt_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_pattern <= '0;
            r_len     <= '0;
            r_target  <= '0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            // match is a single-cycle pulse unless re-asserted below
            r_match <= 1'b0;
            case (r_state)
                c_idle, c_armed: begin
                    // A config request wins over a same-cycle start.
                    if (bus.cfg_valid) begin
                        r_err <= !w_cfg_legal;
                        if (w_cfg_legal) begin
                            r_pattern <= bus.cfg_pattern;
                            r_len     <= bus.cfg_len;
                            r_target  <= bus.cfg_target;
                            r_state   <= c_armed;
                        end
                    end else if ((r_state == c_armed) && bus.start) begin
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_cnt   <= '0;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    // abort suppresses any match completing this cycle
                    if (bus.abort) begin
                        r_state <= c_armed;
                    end else if (bus.in_valid) begin
                        r_hist <= w_hist_next;
                        if (w_hit) begin
                            r_match <= 1'b1;
                            r_cnt   <= w_cnt_inc;
                            if (w_cnt_inc == r_target) begin
                                r_state <= c_done;
                            end
`ifdef SEQ_DET_OVERLAP_EN
                            r_fill <= w_fill_next;
`else
                            r_fill <= 4'd0;
`endif
                        end else begin
                            r_fill <= w_fill_next;
                        end
                    end
                end
                c_done: begin
                    if (bus.abort || bus.ack) begin
                        r_state <= c_armed;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.cfg_ready = (r_state == c_idle) || (r_state == c_armed);
    assign bus.busy      = (r_state == c_run);
    assign bus.done      = (r_state == c_done);
    assign bus.match     = r_match;
    assign bus.match_cnt = r_cnt;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_ctrl
// Description : Self-checking bench for seq_det_ctrl. A table of per-cycle
//               input/expected-output records drives the main scenarios;
//               a hand-written sequence covers asynchronous reset mid-run.
// Options     : honours SEQ_DET_OVERLAP_EN for the overlap-dependent rows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 8;

`ifdef SEQ_DET_OVERLAP_EN
    localparam int OVL = 1;
`else
    localparam int OVL = 0;
`endif

    typedef struct {
        string      name;
        logic       cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic       iv;
        logic       ib;
        logic       ack;
        logic       e_rdy;
        logic       e_busy;
        logic       e_match;
        logic [7:0] e_cnt;
        logic       e_done;
        logic       e_err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm,
                       input logic cv, input logic [7:0] pat, input logic [3:0] len,
                       input logic [7:0] tgt, input logic st, input logic ab,
                       input logic iv, input logic ib, input logic ack,
                       input logic e_rdy, input logic e_busy, input logic e_match,
                       input logic [7:0] e_cnt, input logic e_done, input logic e_err);
        vec_t v;
        v.name = nm; v.cv = cv; v.pat = pat; v.len = len; v.tgt = tgt;
        v.st = st; v.ab = ab; v.iv = iv; v.ib = ib; v.ack = ack;
        v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_match = e_match;
        v.e_cnt = e_cnt; v.e_done = e_done; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    // Streams one qualified bit in RUN with expected status afterwards.
    task automatic add_bit(input string nm, input logic ib, input logic e_busy,
                           input logic e_match, input logic [7:0] e_cnt,
                           input logic e_done, input logic e_err);
        add(nm, 0, 8'h00, 4'd0, 8'd0, 0, 0, 1, ib, 0,
            0, e_busy, e_match, e_cnt, e_done, e_err);
    endtask

    task automatic drive_idle();
        bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
        bus.cfg_target = '0;  bus.start = 1'b0;     bus.abort = 1'b0;
        bus.in_valid = 1'b0;  bus.in_bit = 1'b0;    bus.ack = 1'b0;
    endtask

    task automatic check_outs(input string nm, input logic rdy, input logic busy,
                              input logic m, input logic [7:0] cnt,
                              input logic dn, input logic er);
        check({nm, ".cfg_ready"}, 32'(bus.cfg_ready), 32'(rdy));
        check({nm, ".busy"},      32'(bus.busy),      32'(busy));
        check({nm, ".match"},     32'(bus.match),     32'(m));
        check({nm, ".match_cnt"}, 32'(bus.match_cnt), 32'(cnt));
        check({nm, ".done"},      32'(bus.done),      32'(dn));
        check({nm, ".err"},       32'(bus.err),       32'(er));
    endtask

    initial begin
        logic [7:0] c_ovl;   // match_cnt after the 101 stream (mode-dependent)
        checks = 0;
        errors = 0;
        c_ovl  = (OVL != 0) ? 8'd2 : 8'd1;

        // ---------------- vector table --------------------------------------
        //   name            cv pat   len  tgt  st ab iv ib ack | rdy busy m cnt done err
        add("rst_idle",      0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 0,   1, 0, 0, 8'd0, 0, 0);
        // illegal configs in IDLE: err set, no arming
        add("bad_len0",      1, 8'h34, 4'd0, 8'd1, 0, 0, 0, 0, 0,   1, 0, 0, 8'd0, 0, 1);
        add("idle_start_a",  0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0,   1, 0, 0, 8'd0, 0, 1);
        add("bad_len9",      1, 8'h34, 4'd9, 8'd1, 0, 0, 0, 0, 0,   1, 0, 0, 8'd0, 0, 1);
        add("bad_tgt0",      1, 8'h34, 4'd6, 8'd0, 0, 0, 0, 0, 0,   1, 0, 0, 8'd0, 0, 1);
        add("idle_start_b",  0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0,   1, 0, 0, 8'd0, 0, 1);
        // 110100, len 6, target 1
        add("cfg_110100",    1, 8'h34, 4'd6, 8'd1, 0, 0, 0, 0, 0,   1, 0, 0, 8'd0, 0, 0);
        add("start_a",       0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0,   0, 1, 0, 8'd0, 0, 0);
        add_bit("p6_b1", 1, 1, 0, 8'd0, 0, 0);
        add_bit("p6_b2", 1, 1, 0, 8'd0, 0, 0);
        add_bit("p6_b3", 0, 1, 0, 8'd0, 0, 0);
        add_bit("p6_b4", 1, 1, 0, 8'd0, 0, 0);
        add_bit("p6_b5", 0, 1, 0, 8'd0, 0, 0);
        add_bit("p6_b6", 0, 0, 1, 8'd1, 1, 0);
        add("done_hold",     0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 0,   0, 0, 0, 8'd1, 1, 0);
        add("ack",           0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 1,   1, 0, 0, 8'd1, 0, 0);
        // 101, len 3, target 3: overlap decides the second match
        add("cfg_101",       1, 8'h05, 4'd3, 8'd3, 0, 0, 0, 0, 0,   1, 0, 0, 8'd1, 0, 0);
        add("start_b",       0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0,   0, 1, 0, 8'd0, 0, 0);
        add_bit("s101_b1", 1, 1, 0, 8'd0, 0, 0);
        add_bit("s101_b2", 0, 1, 0, 8'd0, 0, 0);
        add_bit("s101_b3", 1, 1, 1, 8'd1, 0, 0);
        add_bit("s101_b4", 0, 1, 0, 8'd1, 0, 0);
        add_bit("s101_b5", 1, 1, logic'(OVL != 0), c_ovl, 0, 0);
        add("gap_ignored",   0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 1, 0,   0, 1, 0, c_ovl, 0, 0);
        add("abort_run",     0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0, 0,   1, 0, 0, c_ovl, 0, 0);
        // illegal config in ARMED keeps 101; abort on completing bit
        add("armed_bad",     1, 8'hFF, 4'd0, 8'd1, 0, 0, 0, 0, 0,   1, 0, 0, c_ovl, 0, 1);
        add("start_c",       0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0,   0, 1, 0, 8'd0, 0, 1);
        add_bit("ab_b1", 1, 1, 0, 8'd0, 0, 1);
        add_bit("ab_b2", 0, 1, 0, 8'd0, 0, 1);
        add_bit("ab_b3", 1, 1, 1, 8'd1, 0, 1);
        add_bit("ab_b4", 1, 1, 0, 8'd1, 0, 1);
        add_bit("ab_b5", 0, 1, 0, 8'd1, 0, 1);
        add("abort_on_hit",  0, 8'h00, 4'd0, 8'd0, 0, 1, 1, 1, 0,   1, 0, 0, 8'd1, 0, 1);
        // cfg+start together: config taken, start ignored; len-1 back-to-back
        add("cfg_and_start", 1, 8'h01, 4'd1, 8'd3, 1, 0, 0, 0, 0,   1, 0, 0, 8'd1, 0, 0);
        add("start_d",       0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0,   0, 1, 0, 8'd0, 0, 0);
        add_bit("b2b_1", 1, 1, 1, 8'd1, 0, 0);
        add_bit("b2b_2", 1, 1, 1, 8'd2, 0, 0);
        add_bit("b2b_3", 1, 0, 1, 8'd3, 1, 0);
        add_bit("done_ign_bit", 1, 0, 0, 8'd3, 1, 0);
        add("abort_ack_done", 0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0, 1,  1, 0, 0, 8'd3, 0, 0);
        // pattern 10 with gaps, run left mid-stream for the reset check
        add("cfg_10",        1, 8'h02, 4'd2, 8'd5, 0, 0, 0, 0, 0,   1, 0, 0, 8'd3, 0, 0);
        add("armed_bad_t0",  1, 8'h02, 4'd2, 8'd0, 0, 0, 0, 0, 0,   1, 0, 0, 8'd3, 0, 1);
        add("start_e",       0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0,   0, 1, 0, 8'd0, 0, 1);
        add_bit("g_b1", 1, 1, 0, 8'd0, 0, 1);
        add_bit("g_b2", 0, 1, 1, 8'd1, 0, 1);
        add("g_gap1",        0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 0,   0, 1, 0, 8'd1, 0, 1);
        add_bit("g_b3", 1, 1, 0, 8'd1, 0, 1);
        add("g_gap2",        0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 1, 0,   0, 1, 0, 8'd1, 0, 1);
        add_bit("g_b4", 0, 1, 1, 8'd2, 0, 1);
        add("g_gap3",        0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 1, 0,   0, 1, 0, 8'd2, 0, 1);
        add("g_gap4",        0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 0,   0, 1, 0, 8'd2, 0, 1);
        add_bit("g_b5", 1, 1, 0, 8'd2, 0, 1);
        add_bit("g_b6", 0, 1, 1, 8'd3, 0, 1);

        // ---------------- reset and table replay ---------------------------
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.cfg_valid   = vecs[i].cv;
            bus.cfg_pattern = vecs[i].pat;
            bus.cfg_len     = vecs[i].len;
            bus.cfg_target  = vecs[i].tgt;
            bus.start       = vecs[i].st;
            bus.abort       = vecs[i].ab;
            bus.in_valid    = vecs[i].iv;
            bus.in_bit      = vecs[i].ib;
            bus.ack         = vecs[i].ack;
            @(posedge clk);
            #1;
            check_outs(vecs[i].name, vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_match,
                       vecs[i].e_cnt, vecs[i].e_done, vecs[i].e_err);
        end

        // ---------------- asynchronous reset mid-run ------------------------
        drive_idle();
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 1, 0, 0, 8'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_outs("post_rst", 1, 0, 0, 8'd0, 0, 0);
        // stored config was cleared: start in IDLE must not begin a run
        bus.start = 1'b1;
        @(posedge clk);
        #1 check_outs("post_rst_start", 1, 0, 0, 8'd0, 0, 0);
        bus.start       = 1'b0;
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = 8'h02;
        bus.cfg_len     = 4'd2;
        bus.cfg_target  = 8'd1;
        @(posedge clk);
        #1 check_outs("post_rst_cfg", 1, 0, 0, 8'd0, 0, 0);
        drive_idle();
        bus.start = 1'b1;
        @(posedge clk);
        #1 check_outs("post_rst_run", 0, 1, 0, 8'd0, 0, 0);
        drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
